// File: rtl/motor_ramp_ctrl_if.sv
// Command handshake bundle: navigation logic -> motor_ramp_ctrl.
// Carries a direction and a target duty under a valid/ready handshake.
interface motor_ramp_ctrl_if #(
  parameter int DUTY_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [DUTY_W-1:0] cmd_speed;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_speed,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_speed,
    output cmd_ready
  );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Slew-limited duty/direction stage in front of MotorDriver.
// Optional command watchdog: define MOTOR_RAMP_WDT_EN.
module motor_ramp_ctrl #(
  parameter int DUTY_W      = 16,
  parameter int RAMP_DIV    = 1000,
  parameter int RAMP_STEP   = 64,
  parameter int DEAD_CYCLES = 5000
`ifdef MOTOR_RAMP_WDT_EN
  ,
  parameter int WDT_CYCLES  = 50000000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  motor_ramp_ctrl_if.slave  cmd,
  input  logic              estop,
  output logic [DUTY_W-1:0] duty,
  output logic [1:0]        motor_dir,
  output logic              motor_en,
  output logic              at_speed
`ifdef MOTOR_RAMP_WDT_EN
  ,
  output logic              wdt_trip
`endif
);

  typedef enum logic [2:0] {
    S_COAST,
    S_RUN,
    S_REV,
    S_BRAKE,
    S_ESTOP
  } st_e;

  localparam int DW1 = DUTY_W + 1;
  localparam int PW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [PW-1:0]     PRE_LAST = PW'(RAMP_DIV - 1);
  localparam logic [DCW-1:0]    DEAD_LD  = DCW'(DEAD_CYCLES - 1);
  localparam logic [DW1-1:0]    STEP_X   = DW1'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] STEP_N   = DUTY_W'(RAMP_STEP);

  st_e               r_st;
  st_e               w_st_nxt;
  logic [PW-1:0]     r_pre;
  logic [DCW-1:0]    r_dead;
  logic [DUTY_W-1:0] r_tgt;
  logic [DUTY_W-1:0] w_tgt_nxt;
  logic              r_dir;
  logic              w_dir_nxt;
  logic              r_pdir;
  logic [DUTY_W-1:0] r_pspd;

  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] w_duty_nxt;
  logic [1:0]        r_mdir;
  logic [1:0]        w_mdir_nxt;
  logic              r_en;
  logic              w_en_nxt;
  logic              r_ready;
  logic              w_ready_nxt;
  logic              r_at;
  logic              w_at_nxt;

  logic              w_acc;
  logic              w_nz;
  logic              w_same;
  logic              w_tick;
  logic              w_wdt_hit;
  logic              w_rev_go;
  logic              w_brk_done;

  logic [DW1-1:0]    w_d_ext;
  logic [DW1-1:0]    w_t_ext;
  logic [DW1-1:0]    w_up;
  logic [DW1-1:0]    w_dn_lim;
  logic [DUTY_W-1:0] w_ramp;

  assign w_acc      = cmd.cmd_valid && r_ready;
  assign w_nz       = |cmd.cmd_speed;
  assign w_same     = (cmd.cmd_dir == r_dir);
  assign w_tick     = (r_pre == PRE_LAST);
  assign w_rev_go   = (r_st == S_RUN) && w_acc && w_nz && !w_same;
  assign w_brk_done = (r_st == S_BRAKE) && (r_dead == '0);

  assign cmd.cmd_ready = r_ready;
  assign duty          = r_duty;
  assign motor_dir     = r_mdir;
  assign motor_en      = r_en;
  assign at_speed      = r_at;

  // Extra headroom bit keeps step arithmetic free of wrap.
  assign w_d_ext  = {1'b0, r_duty};
  assign w_t_ext  = {1'b0, r_tgt};
  assign w_up     = w_d_ext + STEP_X;
  assign w_dn_lim = w_t_ext + STEP_X;

  // Free-running ramp prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st <= S_COAST;
    end else begin
      r_st <= w_st_nxt;
    end
  end

  // FSM next-state; estop overrides everything.
  always_comb begin
    w_st_nxt = r_st;
    if (estop) begin
      w_st_nxt = S_ESTOP;
    end else begin
      unique case (r_st)
        S_COAST: begin
          if (w_acc && w_nz) w_st_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_rev_go) begin
            w_st_nxt = S_REV;
          end else if (w_acc && w_nz) begin
            w_st_nxt = S_RUN;
          end else if (r_duty == '0 && r_tgt == '0) begin
            w_st_nxt = S_COAST;
          end
        end
        S_REV: begin
          if (r_duty == '0) w_st_nxt = S_BRAKE;
        end
        S_BRAKE: begin
          if (r_dead == '0) w_st_nxt = S_RUN;
        end
        S_ESTOP: w_st_nxt = S_COAST;
        default: w_st_nxt = S_COAST;
      endcase
    end
  end

  // Target and active direction selection.
  always_comb begin
    w_tgt_nxt = r_tgt;
    w_dir_nxt = r_dir;
    if (estop || r_st == S_ESTOP) begin
      w_tgt_nxt = '0;
    end else if (r_st == S_COAST && w_acc && w_nz) begin
      w_tgt_nxt = cmd.cmd_speed;
      w_dir_nxt = cmd.cmd_dir;
    end else if (r_st == S_RUN && w_acc && w_same) begin
      w_tgt_nxt = cmd.cmd_speed;
    end else if (r_st == S_RUN && w_acc) begin
      w_tgt_nxt = '0;
    end else if (r_st == S_RUN && w_wdt_hit) begin
      w_tgt_nxt = '0;
    end else if (w_brk_done) begin
      w_tgt_nxt = r_pspd;
      w_dir_nxt = r_pdir;
    end
  end

  // One ramp step toward the target, clamped at the target.
  always_comb begin
    w_ramp = r_duty;
    if (r_duty < r_tgt) begin
      w_ramp = (w_up >= w_t_ext) ? r_tgt : (r_duty + STEP_N);
    end else if (r_duty > r_tgt) begin
      w_ramp = (w_d_ext <= w_dn_lim) ? r_tgt : (r_duty - STEP_N);
    end
  end

  // FSM outputs, computed for the upcoming state so they register cleanly.
  always_comb begin
    w_duty_nxt  = w_tick ? w_ramp : r_duty;
    w_mdir_nxt  = 2'b00;
    w_en_nxt    = 1'b0;
    w_ready_nxt = 1'b0;
    unique case (w_st_nxt)
      S_COAST: begin
        w_ready_nxt = 1'b1;
      end
      S_RUN: begin
        w_en_nxt    = 1'b1;
        w_ready_nxt = 1'b1;
        w_mdir_nxt  = w_dir_nxt ? 2'b01 : 2'b10;
      end
      S_REV: begin
        w_en_nxt   = 1'b1;
        w_mdir_nxt = r_dir ? 2'b01 : 2'b10;
      end
      S_BRAKE, S_ESTOP: begin
        w_en_nxt   = 1'b1;
        w_mdir_nxt = 2'b11;
        w_duty_nxt = '0;
      end
      default: begin
        w_duty_nxt = '0;
      end
    endcase
    w_at_nxt = (w_st_nxt == S_RUN) && (w_duty_nxt == w_tgt_nxt) &&
               (|w_tgt_nxt);
  end

  // Target, direction, pending reversal and dead-time counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tgt  <= '0;
      r_dir  <= 1'b0;
      r_pdir <= 1'b0;
      r_pspd <= '0;
      r_dead <= '0;
    end else begin
      r_tgt <= w_tgt_nxt;
      r_dir <= w_dir_nxt;
      if (estop || r_st == S_ESTOP) begin
        r_pdir <= 1'b0;
        r_pspd <= '0;
        r_dead <= '0;
      end else begin
        if (w_rev_go) begin
          r_pdir <= cmd.cmd_dir;
          r_pspd <= cmd.cmd_speed;
        end
        if (r_st == S_REV && w_st_nxt == S_BRAKE) begin
          r_dead <= DEAD_LD;
        end else if (r_st == S_BRAKE && r_dead != '0) begin
          r_dead <= r_dead - 1'b1;
        end
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_duty  <= '0;
      r_mdir  <= 2'b00;
      r_en    <= 1'b0;
      r_ready <= 1'b0;
      r_at    <= 1'b0;
    end else begin
      r_duty  <= w_duty_nxt;
      r_mdir  <= w_mdir_nxt;
      r_en    <= w_en_nxt;
      r_ready <= w_ready_nxt;
      r_at    <= w_at_nxt;
    end
  end

`ifdef MOTOR_RAMP_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] r_wdt;
  logic          r_trip;

  assign w_wdt_hit = (r_st == S_RUN) && !w_acc && (r_wdt == WDT_LAST);
  assign wdt_trip  = r_trip;

  // Command watchdog: counts idle RUN cycles, trip is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdt  <= '0;
      r_trip <= 1'b0;
    end else begin
      if (r_st != S_RUN || w_acc) begin
        r_wdt <= '0;
      end else if (r_wdt != WDT_LAST) begin
        r_wdt <= r_wdt + 1'b1;
      end
      if (w_acc && w_nz) begin
        r_trip <= 1'b0;
      end else if (w_wdt_hit) begin
        r_trip <= 1'b1;
      end
    end
  end
`else
  assign w_wdt_hit = 1'b0;
`endif

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl.
// RAMP_DIV=4, RAMP_STEP=64, DEAD_CYCLES=8.
module tb_motor_ramp_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          estop = 1'b0;
  logic [DW-1:0] duty;
  logic [1:0]    motor_dir;
  logic          motor_en;
  logic          at_speed;
`ifdef MOTOR_RAMP_WDT_EN
  logic          wdt_trip;
`endif

  int errors = 0;
  int checks = 0;

  motor_ramp_ctrl_if #(.DUTY_W(DW)) cmd_if ();

  motor_ramp_ctrl #(
    .DUTY_W(DW),
    .RAMP_DIV(4),
    .RAMP_STEP(64),
    .DEAD_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd(cmd_if),
    .estop(estop),
    .duty(duty),
    .motor_dir(motor_dir),
    .motor_en(motor_en),
    .at_speed(at_speed)
`ifdef MOTOR_RAMP_WDT_EN
    ,
    .wdt_trip(wdt_trip)
`endif
  );

  always #5 clk = ~clk;

  task automatic send(input logic d, input logic [DW-1:0] s);
    int n;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = d;
    cmd_if.cmd_speed = s;
    n = 0;
    while (!cmd_if.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: cmd_ready=%b required 1", cmd_if.cmd_ready);
    end else begin
      @(posedge clk);
    end
    #1 cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic next_duty(output logic [DW-1:0] v);
    logic [DW-1:0] old;
    int n;
    old = duty;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (duty == old && n < 16);
    v = duty;
  endtask

  task automatic test_reset;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_speed = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (duty !== 16'd0) begin
      errors++; $display("FAIL rst_duty: got %0d want 0", duty);
    end
    checks++;
    if (motor_dir !== 2'b00) begin
      errors++; $display("FAIL rst_dir: got %b want 00", motor_dir);
    end
    checks++;
    if (motor_en !== 1'b0 || at_speed !== 1'b0) begin
      errors++;
      $display("FAIL rst_en: en=%b at=%b want 0 0", motor_en, at_speed);
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready: got %b want 0", cmd_if.cmd_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || motor_dir !== 2'b00) begin
      errors++;
      $display("FAIL rel_ready: rdy=%b dir=%b want 1 00",
               cmd_if.cmd_ready, motor_dir);
    end
  endtask

  task automatic test_accel;
    logic [DW-1:0] v;
    logic [DW-1:0] exp_q [4] = '{16'd64, 16'd128, 16'd192, 16'd200};
    send(1'b0, 16'd200);
    @(negedge clk);
    checks++;
    if (motor_dir !== 2'b10 || motor_en !== 1'b1) begin
      errors++;
      $display("FAIL run_fwd: dir=%b en=%b want 10 1", motor_dir, motor_en);
    end
    for (int i = 0; i < 4; i++) begin
      next_duty(v);
      checks++;
      if (v !== exp_q[i]) begin
        errors++; $display("FAIL accel_%0d: got %0d want %0d", i, v, exp_q[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (at_speed !== 1'b1) begin
      errors++; $display("FAIL accel_at: got %b want 1", at_speed);
    end
  endtask

  task automatic test_same_cmd;
    send(1'b0, 16'd200);
    repeat (8) @(negedge clk);
    checks++;
    if (duty !== 16'd200 || at_speed !== 1'b1 || motor_dir !== 2'b10) begin
      errors++;
      $display("FAIL same_cmd: duty=%0d at=%b dir=%b want 200 1 10",
               duty, at_speed, motor_dir);
    end
  endtask

  task automatic test_retarget;
    logic [DW-1:0] v;
    logic [DW-1:0] exp_q [3] = '{16'd136, 16'd72, 16'd70};
    send(1'b0, 16'd70);
    for (int i = 0; i < 3; i++) begin
      next_duty(v);
      checks++;
      if (v !== exp_q[i]) begin
        errors++; $display("FAIL down_%0d: got %0d want %0d", i, v, exp_q[i]);
      end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (duty !== 16'd70 || at_speed !== 1'b1) begin
      errors++;
      $display("FAIL down_hold: duty=%0d at=%b want 70 1", duty, at_speed);
    end
    send(1'b0, 16'd128);
    next_duty(v);
    checks++;
    if (v !== 16'd128) begin
      errors++; $display("FAIL up_clamp: got %0d want 128", v);
    end
  endtask

  task automatic test_reversal;
    logic [DW-1:0] v;
    int n;
    int cnt;
    send(1'b1, 16'd64);
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_ready !== 1'b0 || motor_dir !== 2'b10) begin
      errors++;
      $display("FAIL rev_enter: rdy=%b dir=%b want 0 10",
               cmd_if.cmd_ready, motor_dir);
    end
    next_duty(v);
    checks++;
    if (v !== 16'd64) begin
      errors++; $display("FAIL rev_down1: got %0d want 64", v);
    end
    next_duty(v);
    checks++;
    if (v !== 16'd0) begin
      errors++; $display("FAIL rev_down2: got %0d want 0", v);
    end
    n = 0;
    while (motor_dir !== 2'b11 && n < 10) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    while (motor_dir === 2'b11 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 8) begin
      errors++; $display("FAIL brake_len: got %0d cycles want 8", cnt);
    end
    checks++;
    if (motor_dir !== 2'b01 || cmd_if.cmd_ready !== 1'b1 || duty !== 16'd0) begin
      errors++;
      $display("FAIL rev_run: dir=%b rdy=%b duty=%0d want 01 1 0",
               motor_dir, cmd_if.cmd_ready, duty);
    end
    next_duty(v);
    checks++;
    if (v !== 16'd64) begin
      errors++; $display("FAIL rev_up: got %0d want 64", v);
    end
    @(negedge clk);
    checks++;
    if (at_speed !== 1'b1 || motor_dir !== 2'b01) begin
      errors++;
      $display("FAIL rev_at: at=%b dir=%b want 1 01", at_speed, motor_dir);
    end
  endtask

  task automatic test_stop;
    logic [DW-1:0] v;
    send(1'b1, 16'd0);
    next_duty(v);
    checks++;
    if (v !== 16'd0) begin
      errors++; $display("FAIL stop_duty: got %0d want 0", v);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (motor_en !== 1'b0 || motor_dir !== 2'b00 || at_speed !== 1'b0) begin
      errors++;
      $display("FAIL stop_coast: en=%b dir=%b at=%b want 0 00 0",
               motor_en, motor_dir, at_speed);
    end
  endtask

  task automatic test_estop;
    logic [DW-1:0] v;
    int n;
    send(1'b0, 16'd64);
    next_duty(v);
    send(1'b1, 16'd64);
    n = 0;
    while (motor_dir !== 2'b11 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (motor_dir !== 2'b11) begin
      errors++; $display("FAIL es_brake: dir=%b want 11", motor_dir);
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = 1'b1;
    cmd_if.cmd_speed = 16'd200;
    estop = 1'b1;
    @(negedge clk);
    checks++;
    if (duty !== 16'd0 || motor_dir !== 2'b11 || motor_en !== 1'b1 ||
        cmd_if.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL es_on: duty=%0d dir=%b en=%b rdy=%b want 0 11 1 0",
               duty, motor_dir, motor_en, cmd_if.cmd_ready);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (duty !== 16'd0 || motor_dir !== 2'b11) begin
      errors++;
      $display("FAIL es_hold: duty=%0d dir=%b want 0 11", duty, motor_dir);
    end
    cmd_if.cmd_valid = 1'b0;
    estop = 1'b0;
    @(negedge clk);
    checks++;
    if (motor_dir !== 2'b00 || motor_en !== 1'b0 ||
        cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL es_off: dir=%b en=%b rdy=%b want 00 0 1",
               motor_dir, motor_en, cmd_if.cmd_ready);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (duty !== 16'd0 || motor_dir !== 2'b00) begin
      errors++;
      $display("FAIL es_drop: duty=%0d dir=%b want 0 00", duty, motor_dir);
    end
  endtask

  task automatic test_reset_midramp;
    int n;
    send(1'b0, 16'd200);
    n = 0;
    while (duty !== 16'd128 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (duty !== 16'd128) begin
      errors++; $display("FAIL mid_reach: got %0d want 128", duty);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (duty !== 16'd0 || motor_dir !== 2'b00 || motor_en !== 1'b0 ||
        cmd_if.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: duty=%0d dir=%b en=%b rdy=%b want 0 00 0 0",
               duty, motor_dir, motor_en, cmd_if.cmd_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_if.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rel0: rdy=%b want 0", cmd_if.cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rel1: rdy=%b want 1", cmd_if.cmd_ready);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (duty !== 16'd0 || motor_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: duty=%0d en=%b want 0 0", duty, motor_en);
    end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_same_cmd();
    test_retarget();
    test_reversal();
    test_stop();
    test_estop();
    test_reset_midramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
